// File: rtl/core_input_ctrl.sv
// Input staging for the 8x8 systolic core: per-lane activation/weight FIFOs
// drained with a diagonal skew so lane k pops k cycles after lane 0.
module core_input_ctrl #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] ainport [0:LANES-1],
  input  logic [DW-1:0] winport [0:LANES-1],
  input  logic          write,
  input  logic          read,
  output logic [0:LANES-1] aemptys,
  output logic [0:LANES-1] wemptys,
  output logic [DW-1:0] as [0:LANES-1],
  output logic [DW-1:0] ws [0:LANES-1]
);

  localparam int AW = $clog2(DEPTH);
  localparam int NF = 2 * LANES;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [LANES-1:1] skew;
  logic [LANES-1:0] rdq;

  // rdq[k] is the read strobe delayed by k cycles; rdq[0] is the live input
  assign rdq = {skew, read};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skew <= '0;
    end else begin
      skew <= rdq[LANES-2:0];
    end
  end

  // FIFOs 0..LANES-1 carry activations, LANES..2*LANES-1 carry weights
  for (genvar j = 0; j < NF; j++) begin : g_fifo
    localparam int K = j % LANES;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [DW-1:0] wdata;
    logic [DW-1:0] q;
    logic          emp;
    logic          push;
    logic          pop;

    if (j < LANES) begin : g_act
      assign wdata      = ainport[K];
      assign as[K]      = q;
      assign aemptys[K] = emp;
    end else begin : g_wgt
      assign wdata      = winport[K];
      assign ws[K]      = q;
      assign wemptys[K] = emp;
    end

    assign emp  = (count == '0);
    assign pop  = rdq[K] & ~emp;
    // a pop in the same cycle frees a slot, so a full FIFO may still accept
    assign push = write & ((count != FULL) | pop);

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wptr] <= wdata;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        q     <= '0;
      end else begin
        q <= pop ? mem[rptr] : '0;
        if (push) begin
          wptr <= wptr + 1'b1;
        end
        if (pop) begin
          rptr <= rptr + 1'b1;
        end
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_input_ctrl.sv
// Scoreboard bench for core_input_ctrl: a queue-based reference model predicts
// each edge's outputs, plus directed checks for the characteristic scenarios.
module tb_core_input_ctrl;

  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] w;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] ainport [0:LANES-1];
  logic [DW-1:0] winport [0:LANES-1];
  logic          write;
  logic          read;
  logic [0:LANES-1] aemptys;
  logic [0:LANES-1] wemptys;
  logic [DW-1:0] as_o [0:LANES-1];
  logic [DW-1:0] ws_o [0:LANES-1];
  logic [63:0]   as_pk;
  logic [63:0]   ws_pk;

  logic [7:0]       mq [2*LANES][$];
  logic [LANES-1:1] mskew;
  exp_t             sb [$];

  int vectors     = 0;
  int miscompares = 0;

  core_input_ctrl #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .ainport (ainport),
    .winport (winport),
    .write   (write),
    .read    (read),
    .aemptys (aemptys),
    .wemptys (wemptys),
    .as      (as_o),
    .ws      (ws_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    as_pk = '0;
    ws_pk = '0;
    for (int k = 0; k < LANES; k++) begin
      as_pk[8*k +: 8] = as_o[k];
      ws_pk[8*k +: 8] = ws_o[k];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drives one cycle, predicts the edge with the model, then compares after the edge
  task automatic applyStimulus(input logic w, input logic r, input logic [7:0] abase,
                               input logic [7:0] wbase, input logic [7:0] stride);
    exp_t             e;
    exp_t             got;
    logic [LANES-1:0] rq;
    logic [0:LANES-1] expa;
    logic [0:LANES-1] expw;
    logic [7:0]       d;
    int               k;
    write = w;
    read  = r;
    for (int i = 0; i < LANES; i++) begin
      ainport[i] = abase + stride * 8'(i);
      winport[i] = wbase + stride * 8'(i);
      expa[i]    = (mq[i].size() == 0);
      expw[i]    = (mq[LANES+i].size() == 0);
    end
    checkOutput("aemptys", {56'b0, aemptys}, {56'b0, expa});
    checkOutput("wemptys", {56'b0, wemptys}, {56'b0, expw});
    e  = '0;
    rq = {mskew, r};
    for (int j = 0; j < 2*LANES; j++) begin
      k = j % LANES;
      d = 8'h00;
      if (rq[k] && mq[j].size() != 0) begin
        d = mq[j].pop_front();
      end
      if (w && mq[j].size() < DEPTH) begin
        mq[j].push_back(j < LANES ? ainport[k] : winport[k]);
      end
      if (j < LANES) e.a[8*k +: 8] = d;
      else           e.w[8*k +: 8] = d;
    end
    mskew = rq[LANES-2:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput("as", as_pk, got.a);
    checkOutput("ws", ws_pk, got.w);
  endtask

  task automatic applyReset();
    write = 1'b0;
    read  = 1'b0;
    rstn  = 1'b0;
    #1;
    checkOutput("rst_aemptys", {56'b0, aemptys}, 64'hFF);
    checkOutput("rst_wemptys", {56'b0, wemptys}, 64'hFF);
    checkOutput("rst_as", as_pk, 64'h0);
    checkOutput("rst_ws", ws_pk, 64'h0);
    for (int j = 0; j < 2*LANES; j++) mq[j].delete();
    mskew = '0;
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  int          cnt [LANES];
  int          sum [LANES];
  logic [7:0]  last0;
  logic [63:0] expv;

  initial begin
    write = 1'b0;
    read  = 1'b0;
    rstn  = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      ainport[i] = '0;
      winport[i] = '0;
    end
    #12;
    applyReset();

    // single write then a one-cycle read pulse
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h10, 8'h01);
    checkOutput("single_aemptys", {56'b0, aemptys}, 64'h0);
    for (int i = 0; i <= LANES; i++) begin
      if (i == 0) applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
      else        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      expv = '0;
      for (int k = 0; k < LANES; k++) if (k == i) expv[8*k +: 8] = 8'(k + 1);
      checkOutput("single_as", as_pk, expv);
      expv = '0;
      for (int k = 0; k < LANES; k++) if (k == i) expv[8*k +: 8] = 8'h10 + 8'(k);
      checkOutput("single_ws", ws_pk, expv);
    end
    idle(2);
    checkOutput("single_drained", {56'b0, aemptys, wemptys}, 64'hFFFF);

    // streaming
    for (int n = 0; n < 16; n++) applyStimulus(1'b1, 1'b1, 8'(n), 8'h40 + 8'(n), 8'h00);
    for (int n = 0; n < 8; n++)  applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    checkOutput("stream_empty", {56'b0, aemptys, wemptys}, 64'hFFFF);
    idle(8);

    // overflow: 17 pushes, the last is dropped
    for (int v = 1; v <= 17; v++) applyStimulus(1'b1, 1'b0, 8'(v), 8'h80 + 8'(v), 8'h00);
    checkOutput("ovf_aemptys", {56'b0, aemptys}, 64'h0);
    for (int k = 0; k < LANES; k++) begin
      cnt[k] = 0;
      sum[k] = 0;
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, (i < 24), 8'h00, 8'h00, 8'h00);
      for (int k = 0; k < LANES; k++) begin
        if (as_o[k] != 0) begin
          cnt[k]++;
          sum[k] += int'(as_o[k]);
        end
      end
    end
    for (int k = 0; k < LANES; k++) begin
      checkOutput("ovf_cnt", 64'(cnt[k]), 64'd16);
      checkOutput("ovf_sum", 64'(sum[k]), 64'd136);
    end

    // read on empty
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    checkOutput("empty_read_as", as_pk, 64'h0);
    checkOutput("empty_read_flags", {56'b0, aemptys, wemptys}, 64'hFFFF);
    idle(8);

    // simultaneous push/pop on a full FIFO
    for (int v = 1; v <= 16; v++) applyStimulus(1'b1, 1'b0, 8'(v), 8'(v), 8'h00);
    applyStimulus(1'b1, 1'b1, 8'd99, 8'd99, 8'h00);
    checkOutput("full_pp_as0", {56'b0, as_pk[7:0]}, 64'd1);
    cnt[0] = 0;
    last0  = 8'h00;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b0, (i < 16), 8'h00, 8'h00, 8'h00);
      if (as_o[0] != 0) begin
        cnt[0]++;
        last0 = as_o[0];
      end
    end
    checkOutput("full_pp_cnt0", 64'(cnt[0]), 64'd16);
    checkOutput("full_pp_last0", {56'b0, last0}, 64'd99);

    // reset mid-operation discards everything
    for (int v = 1; v <= 3; v++) applyStimulus(1'b1, 1'b0, 8'(v), 8'(v), 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    #3;
    applyReset();
    checkOutput("post_rst_flags", {56'b0, aemptys, wemptys}, 64'hFFFF);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, (i < 2), 8'h00, 8'h00, 8'h00);
    checkOutput("post_rst_as", as_pk, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
